// File: rtl/rv32_pkg.sv
// Shared RV32 constants and types used by the fetch stage and its buffers.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Instruction fetch is word-granular; low address bits are never honoured.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; empty reads return zero so idle outputs stay quiet.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// RV32I fetch stage: PC sequencing, imem req/gnt issue, in-order response
// buffering toward decode, and redirect flush with in-flight response dropping.
module inst_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]       r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;

  logic             w_run;
  logic [CNT_W:0]   w_sum;
  logic             w_issue;
  logic             w_rsp;
  logic [CNT_W-1:0] w_out_next;

  logic             w_buf_push;
  logic             w_buf_pop;
  logic [CNT_W-1:0] w_buf_count;
  logic             w_buf_full;
  logic             w_buf_empty;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  logic [31:0]      w_tag_pc;
  logic [CNT_W-1:0] w_tag_count;
  logic             w_tag_full;
  logic             w_tag_empty;

  assign w_run = (r_state == S_RUN);

  // Buffered words plus in-flight requests never exceed the buffer size,
  // so every response has a guaranteed slot.
  assign w_sum     = {1'b0, r_outstanding} + {1'b0, w_buf_count};
  assign imem_req  = w_run && (w_sum < DEPTH_C);
  assign imem_addr = r_pc;
  assign w_issue   = imem_req && imem_gnt;
  assign w_rsp     = imem_rvalid;

  assign w_out_next = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_rsp);

  assign w_push_entry.pc   = w_tag_pc;
  assign w_push_entry.inst = imem_rdata;
  assign w_buf_push = w_rsp && (r_drop == '0) && !redirect;
  assign w_buf_pop  = inst_valid && inst_ready && !redirect;

  assign inst_valid = !w_buf_empty;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= align_pc(RESET_PC);
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= S_RUN;
      r_outstanding <= w_out_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_pc   <= align_pc(redirect_pc);
        r_drop <= w_out_next;
      end else begin
        if (w_issue) r_pc <= r_pc + PC_STEP;
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_inst_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect),
    .i_push  (w_buf_push),
    .i_din   (w_push_entry),
    .i_pop   (w_buf_pop),
    .o_dout  (w_head),
    .o_count (w_buf_count),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  // Request PCs ride alongside the outstanding count; never flushed, since
  // dropped responses must still retire their tag in order.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_push  (w_issue),
    .i_din   (r_pc),
    .i_pop   (w_rsp),
    .o_dout  (w_tag_pc),
    .o_count (w_tag_count),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    w_tag_count == r_outstanding);
  a_no_issue_when_tags_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_issue && w_tag_full));
  a_no_orphan_response: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && w_tag_empty));
  a_no_buffer_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_buf_push && w_buf_full && !w_buf_pop));

endmodule
